// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
// Polyphonic voice scheduler. Takes decoded 3-byte MIDI messages and maps note-on/note-off
// events onto NUM_VOICES voice slots. A note-on goes to one of these, in order of preference:
// a voice already playing that note (retrigger), the lowest free voice, or the oldest active
// voice (steal). The scan visits one voice per cycle, so a note message takes NUM_VOICES+3
// cycles from acceptance to the next ready.
//
// Ports:
//   i_clk          system clock
//   i_nrst         synchronous active-low reset
//   i_msg_valid    message present; accepted when o_ready is high
//   i_msg          [23:16] status, [15:8] note, [7:0] velocity
//   o_ready        allocator idle, can accept a message
//   o_voice_active per-voice sounding flag
//   o_voice_note   7-bit note per voice, voice i in [7i+6:7i]
//   o_voice_vel    7-bit velocity per voice, same packing
//   o_voice_trig   one-cycle pulse when voice i is (re)assigned
//   o_steal        one-cycle pulse when an active voice was stolen
module midi_voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned CHANNEL    = 0,
  parameter bit          OMNI       = 1'b0,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_msg_valid,
  input  logic [23:0]             i_msg,
  output logic                    o_ready,
  output logic [NUM_VOICES-1:0]   o_voice_active,
  output logic [7*NUM_VOICES-1:0] o_voice_note,
  output logic [7*NUM_VOICES-1:0] o_voice_vel,
  output logic [NUM_VOICES-1:0]   o_voice_trig,
  output logic                    o_steal
);

  localparam int unsigned IdxW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);
  localparam logic [3:0]      ChanNib = 4'(CHANNEL);

  typedef enum logic [1:0] {StIdle, StDecode, StScan, StCommit} state_e;
  typedef enum logic [1:0] {OpNone, OpOn, OpOff, OpAllOff} op_e;

  state_e state_q, state_d;
  op_e    op_q, op_d;

  // Data bytes are stored already masked to 7 bits.
  logic [7:0] status_q, status_d;
  logic [6:0] key_q, key_d;
  logic [6:0] kvel_q, kvel_d;

  logic [IdxW-1:0] idx_q, idx_d;
  logic            match_found_q, match_found_d;
  logic [IdxW-1:0] match_idx_q, match_idx_d;
  logic            free_found_q, free_found_d;
  logic [IdxW-1:0] free_idx_q, free_idx_d;
  logic            old_found_q, old_found_d;
  logic [IdxW-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  steal_q, steal_d;
  logic [6:0]       note_q [NUM_VOICES];
  logic [6:0]       note_d [NUM_VOICES];
  logic [6:0]       vel_q  [NUM_VOICES];
  logic [6:0]       vel_d  [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_d  [NUM_VOICES];

  logic [IdxW-1:0] tgt;
  logic            unused_msg_bits;
  assign unused_msg_bits = ^{i_msg[15], i_msg[7]};

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    status_d      = status_q;
    key_d         = key_q;
    kvel_d        = kvel_q;
    idx_d         = idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    active_d      = active_q;
    trig_d        = '0;
    steal_d       = 1'b0;
    note_d        = note_q;
    vel_d         = vel_q;
    age_d         = age_q;
    tgt           = '0;

    unique case (state_q)
      StIdle: begin
        if (i_msg_valid) begin
          status_d = i_msg[23:16];
          key_d    = i_msg[14:8];
          kvel_d   = i_msg[6:0];
          state_d  = StDecode;
        end
      end
      StDecode: begin
        state_d       = StIdle;
        op_d          = OpNone;
        idx_d         = '0;
        match_found_d = 1'b0;
        free_found_d  = 1'b0;
        old_found_d   = 1'b0;
        old_age_d     = '0;
        if (status_q[7] && (OMNI || (status_q[3:0] == ChanNib))) begin
          if (status_q[6:4] == 3'h1) begin
            // Note-on with zero velocity is a note-off by MIDI convention.
            op_d    = (kvel_q != 7'd0) ? OpOn : OpOff;
            state_d = StScan;
          end else if (status_q[6:4] == 3'h0) begin
            op_d    = OpOff;
            state_d = StScan;
          end else if ((status_q[6:4] == 3'h3) && (key_q == 7'd123)) begin
            op_d    = OpAllOff;
            state_d = StCommit;
          end
        end
      end
      StScan: begin
        if (active_q[idx_q] && (note_q[idx_q] == key_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!active_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (active_q[idx_q] && (!old_found_q || (age_q[idx_q] > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = age_q[idx_q];
        end
        if (idx_q == LastIdx) begin
          state_d = StCommit;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StCommit: begin
        state_d = StIdle;
        unique case (op_q)
          OpOn: begin
            if (match_found_q) begin
              tgt = match_idx_q;
            end else if (free_found_q) begin
              tgt = free_idx_q;
            end else begin
              tgt     = old_idx_q;
              steal_d = 1'b1;
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IdxW'(i) == tgt) begin
                note_d[i]   = key_q;
                vel_d[i]    = kvel_q;
                active_d[i] = 1'b1;
                age_d[i]    = '0;
                trig_d[i]   = 1'b1;
              end else if (active_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
          end
          OpOff: begin
            if (match_found_q) begin
              active_d[match_idx_q] = 1'b0;
            end
          end
          OpAllOff: active_d = '0;
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q       <= StIdle;
      op_q          <= OpNone;
      status_q      <= '0;
      key_q         <= '0;
      kvel_q        <= '0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      active_q      <= '0;
      trig_q        <= '0;
      steal_q       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      status_q      <= status_d;
      key_q         <= key_d;
      kvel_q        <= kvel_d;
      idx_q         <= idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      active_q      <= active_d;
      trig_q        <= trig_d;
      steal_q       <= steal_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
    end
  end

  always_comb begin
    o_voice_note = '0;
    o_voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      o_voice_note[7*i +: 7] = note_q[i];
      o_voice_vel[7*i +: 7]  = vel_q[i];
    end
  end

  assign o_ready        = (state_q == StIdle);
  assign o_voice_active = active_q;
  assign o_voice_trig   = trig_q;
  assign o_steal        = steal_q;

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Polyphonic voice scheduler between the MIDI receiver and the per-voice frequency/oscillator datapath. Accepts decoded 3-byte MIDI messages, maps note-on/note-off events onto a pool of NUM_VOICES voice slots (retrigger, free-slot allocation, oldest-voice stealing), and presents per-voice note, velocity, active flag and trigger pulse. Each voice's note output feeds one MIDI-to-frequency converter and oscillator.

## Interface
- NUM_VOICES, 4: voice slots, 2..16.
- CHANNEL, 0: MIDI channel (0..15) accepted when OMNI=0.
- OMNI, 0: 1 = accept all channels.
- AGE_W, 8: width of the per-voice age counter.

- i_clk  in  1  system clock (50 MHz).
- i_nrst  in  1  reset, synchronous, active-low.
- i_msg_valid  in  1  message present.
- i_msg  in  24  [23:16] status, [15:8] data1 (note), [7:0] data2 (velocity).
- o_ready  out  1  allocator can accept a message.
- o_voice_active  out  NUM_VOICES  voice is sounding.
- o_voice_note  out  7*NUM_VOICES  note of voice i in bits [7i+6:7i].
- o_voice_vel  out  7*NUM_VOICES  velocity of voice i, same packing.
- o_voice_trig  out  NUM_VOICES  one-cycle pulse when voice i is (re)assigned.
- o_steal  out  1  one-cycle pulse when an active voice was stolen.

## Operation
- Handshake: message accepted on a rising edge with i_msg_valid=1 and o_ready=1. o_ready = (state==IDLE). Messages at other times are ignored, not queued.
- Data bytes are masked to 7 bits. A status byte with bit 7 = 0 is dropped.
- FSM: IDLE -> DECODE -> SCAN -> COMMIT -> IDLE.
  - IDLE: captures i_msg on acceptance.
  - DECODE: classifies the message.
    - Channel mismatch (OMNI=0 and status[3:0]!=CHANNEL) -> IDLE (drop).
    - status[7:4]=0x9 and vel!=0 -> NOTE_ON, go to SCAN.
    - status[7:4]=0x8, or 0x9 with vel=0 -> NOTE_OFF, go to SCAN.
    - status[7:4]=0xB and data1=123 -> ALL_OFF, go to COMMIT.
    - Anything else -> IDLE (drop).
  - SCAN: examines one voice per cycle, index 0..NUM_VOICES-1, tracking:
    - first active voice with matching note;
    - lowest-index inactive voice;
    - active voice with largest age, ties to lowest index.
  - COMMIT: applies the result, returns to IDLE.
- NOTE_ON priority:
  1. Matching active voice: retrigger it (update velocity).
  2. Otherwise the lowest free voice.
  3. Otherwise steal the oldest voice and pulse o_steal.
- On NOTE_ON, the chosen voice:
  - gets note/vel loaded, active set, age cleared to 0;
  - pulses its o_voice_trig bit.
  - Every other active voice's age increments, saturating at 2^AGE_W-1. Inactive voices' ages are unchanged.
- NOTE_OFF: clears active on the first matching active voice. Note and vel hold their values. No match -> no change.
- ALL_OFF: clears all active bits. Notes, velocities and ages hold.

## Timing
- Acceptance edge is E0.
- NOTE_ON/NOTE_OFF: voice outputs and pulses update at edge E0+NUM_VOICES+2. o_ready is 0 from E0 through that edge, then 1.
- ALL_OFF: outputs update at E0+2, o_ready is 1 from E0+2.
- Dropped message: o_ready is 1 again from E0+1.
- o_voice_trig and o_steal are high for exactly one cycle, coincident with the voice output update.
- Sustained throughput for note messages is one message per NUM_VOICES+3 cycles.
- Reset (i_nrst=0 at an edge), including mid-SCAN/COMMIT:
  - state returns to IDLE and the in-flight message is discarded;
  - o_voice_active=0, notes=0, vel=0, ages=0;
  - o_voice_trig=0, o_steal=0.
  - o_ready=1 from the first edge after i_nrst rises. Input is ignored while i_nrst=0.
- All outputs are registered except o_ready, which is decoded from the state register.

## Test plan
- Reset, then send 0x903C64 -> after 6 cycles (N=4): voice0 active, note 0x3C, vel 0x64, trig[0] pulse, o_steal=0.
- Send 0x903C40, 0x904040, 0x904340, 0x904840, then 0x904C40 -> the fifth note steals voice0 (oldest): note 0x4C, o_steal pulse, trig[0].
- With 0x3C held on voice0, send 0x903C7F -> voice0 retriggered with vel 0x7F, no other voice changes. Then send 0x803C00 -> voice0 inactive, note stays 0x3C.
- Send 0x903C00 -> treated as note-off. Send 0x91xxxx with CHANNEL=0, OMNI=0 -> dropped, o_ready back to 1 after 1 cycle.
- With 3 voices active, send 0xB07B00 -> all inactive at E0+2. A note-off for a note not present leaves all voices unchanged.
- Assert i_nrst=0 during SCAN of a note-on -> no voice changes, no pulses. o_ready=1 after release, and the next message is processed normally.
- Hold i_msg_valid high while busy -> exactly one message is accepted per o_ready window.
